// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Byte-stream interface between the UART receiver and its consumer.
//   rdata   : received byte, LSB = first data bit on the wire
//   rvalid  : rdata holds an unconsumed byte
//   rready  : consumer accepts rdata when rvalid && rready at a clock edge
//   ferr    : one-cycle pulse, stop bit sampled low, byte discarded
//   overrun : one-cycle pulse, byte completed while the buffer was full
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       ferr;
    logic       overrun;

    modport master (
        output rdata,
        output rvalid,
        output ferr,
        output overrun,
        input  rready
    );

    modport slave (
        input  rdata,
        input  rvalid,
        input  ferr,
        input  overrun,
        output rready
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The asynchronous rxd line is synchronised, a falling edge
// starts a frame, and every bit is sampled once near its middle. A single-byte
// buffer is presented on a valid/ready interface; framing errors and overruns
// are reported as one-cycle pulses.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset (0 = reset)
//   rxd  : serial line, idle high, asynchronous to clk
//   rx   : byte-stream interface (master side), see uart_rx_if
// Parameter:
//   WAIT_DIV : clock cycles per UART bit (>= 4)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int WAIT_DIV = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master rx
);

    localparam int CW = $clog2(WAIT_DIV);
    localparam logic [CW-1:0] HALF = CW'((WAIT_DIV - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(WAIT_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [2:0]    live_q;
    logic [7:0]    rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    logic          rxd_s;
    logic          armed;
    logic          byte_done;
    logic          frame_err;
    logic          drain;

    assign rxd_s = sync2_q;
    // The sync flops and prev_q come out of reset as "idle high". Edge
    // detection waits until the whole chain has been refilled from the real
    // line, so a line that is low when reset releases never looks like a
    // fresh start edge.
    assign armed = live_q[2];
    assign drain = rvalid_q && rx.rready;

    // State register and all sequential state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            live_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sync1_q  <= rxd;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            live_q   <= {live_q[1:0], 1'b1};
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state logic: bit timing, deserialisation and frame checks
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (armed && !rxd_s && prev_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (wait_q == HALF) begin
                    // A line back high at mid start bit was only a glitch.
                    wait_d  = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            DATA: begin
                if (wait_q == LAST) begin
                    wait_d  = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            STOP: begin
                if (wait_q == LAST) begin
                    wait_d = '0;
                    if (rxd_s) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                // A break holds the line low: report it once, then wait.
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: byte buffer, handshake and status pulses
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        ferr_d   = frame_err;
        ovr_d    = 1'b0;
        if (drain) begin
            rvalid_d = 1'b0;
        end
        if (byte_done) begin
            // A buffer being drained in this very cycle counts as free.
            if (!rvalid_q || drain) begin
                rdata_d  = shift_q;
                rvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx.rdata   = rdata_q;
    assign rx.rvalid  = rvalid_q;
    assign rx.ferr    = ferr_q;
    assign rx.overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx: one instance with WAIT_DIV=5 and one with
// WAIT_DIV=8, each with its own line and byte interface.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rxd5;
    logic rxd8;

    uart_rx_if bus5 ();
    uart_rx_if bus8 ();

    uart_rx #(.WAIT_DIV(5)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .rxd (rxd5),
        .rx  (bus5.master)
    );

    uart_rx #(.WAIT_DIV(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .rxd (rxd8),
        .rx  (bus8.master)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters for the WAIT_DIV=5 instance, sampled on the falling edge.
    int         rv_rises = 0;
    int         rv_hi    = 0;
    int         rv_cyc   = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    logic [7:0] last_byte = 8'h00;
    logic       rv_prev   = 1'b0;

    always @(negedge clk) begin
        if (bus5.rvalid) rv_hi <= rv_hi + 1;
        if (bus5.rvalid && !rv_prev) begin
            rv_rises  <= rv_rises + 1;
            rv_cyc    <= cyc;
            last_byte <= bus5.rdata;
        end
        rv_prev <= bus5.rvalid;
        if (bus5.ferr)    ferr_cnt <= ferr_cnt + 1;
        if (bus5.overrun) ovr_cnt  <= ovr_cnt + 1;
    end

    // Accepted bytes and status pulses of the WAIT_DIV=8 instance.
    logic [7:0] q8[$];
    int         ferr8_cnt = 0;
    int         ovr8_cnt  = 0;

    always @(negedge clk) begin
        if (bus8.rvalid && bus8.rready) q8.push_back(bus8.rdata);
        if (bus8.ferr)    ferr8_cnt <= ferr8_cnt + 1;
        if (bus8.overrun) ovr8_cnt  <= ovr8_cnt + 1;
    end

    int b_rises, b_hi, b_ferr, b_ovr;

    task automatic snap();
        b_rises = rv_rises;
        b_hi    = rv_hi;
        b_ferr  = ferr_cnt;
        b_ovr   = ovr_cnt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the active edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit w8, input logic v);
        if (w8) rxd8 = v;
        else    rxd5 = v;
    endtask

    // Drive one frame (start, 8 data bits LSB first, stop). Called 1 time
    // unit after an edge; the line keeps the stop value afterwards.
    task automatic send(input bit w8, input logic [7:0] b, input logic stop, input int stop_len);
        int         w;
        logic [9:0] fr;
        w  = w8 ? 8 : 5;
        fr = {stop, b, 1'b0};
        if (!w8) fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            set_line(w8, fr[i]);
            step((i == 9) ? stop_len : w);
        end
    endtask

    // Full 5-clock frame on the WAIT_DIV=5 line, rready held high.
    task automatic frame_check(input logic [7:0] b);
        snap();
        send(1'b0, b, 1'b1, 5);
        step(6);
        chk("frame_rvalid_rises", rv_rises - b_rises, 1);
        chk("frame_latency",      rv_cyc - fall_cyc, 51);
        chk("frame_rdata",        last_byte, b);
        chk("frame_rvalid_width", rv_hi - b_hi, 1);
        chk("frame_ferr",         ferr_cnt - b_ferr, 0);
        chk("frame_overrun",      ovr_cnt - b_ovr, 0);
    endtask

    initial begin
        rst         = 1'b0;
        rxd5        = 1'b1;
        rxd8        = 1'b1;
        bus5.rready = 1'b1;
        bus8.rready = 1'b1;

        // Reset state
        step(3);
        chk("reset_rvalid",  bus5.rvalid, 0);
        chk("reset_rdata",   bus5.rdata, 8'h00);
        chk("reset_ferr",    bus5.ferr, 0);
        chk("reset_overrun", bus5.overrun, 0);
        rst = 1'b1;
        step(5);

        // Plain frames
        frame_check(8'h55);
        frame_check(8'h00);
        frame_check(8'hFF);
        frame_check(8'hA3);

        // Two-clock low glitch is rejected at mid start bit
        snap();
        rxd5 = 1'b0;
        step(2);
        rxd5 = 1'b1;
        step(12);
        chk("glitch_rvalid", rv_rises - b_rises, 0);
        chk("glitch_ferr",   ferr_cnt - b_ferr, 0);
        frame_check(8'h3C);

        // Stop bit low followed by a long break: one ferr, no byte
        snap();
        send(1'b0, 8'h81, 1'b0, 5);
        rxd5 = 1'b0;
        step(30);
        rxd5 = 1'b1;
        step(10);
        chk("break_ferr_count", ferr_cnt - b_ferr, 1);
        chk("break_rvalid",     rv_rises - b_rises, 0);
        frame_check(8'h42);

        // Overrun with the consumer stalled
        bus5.rready = 1'b0;
        snap();
        send(1'b0, 8'h11, 1'b1, 5);
        send(1'b0, 8'h22, 1'b1, 5);
        step(6);
        chk("ovr_rvalid", bus5.rvalid, 1);
        chk("ovr_rdata",  bus5.rdata, 8'h11);
        chk("ovr_count",  ovr_cnt - b_ovr, 1);
        bus5.rready = 1'b1;
        step(1);
        bus5.rready = 1'b0;
        chk("drain_rvalid", bus5.rvalid, 0);
        chk("drain_rdata",  bus5.rdata, 8'h11);

        // Drain in the same cycle as the next completion: no overrun
        snap();
        send(1'b0, 8'h11, 1'b1, 5);
        step(3);
        chk("pend_rdata", bus5.rdata, 8'h11);
        fork
            send(1'b0, 8'h22, 1'b1, 5);
            begin
                step(50);
                bus5.rready = 1'b1;
                step(1);
                bus5.rready = 1'b0;
            end
        join
        step(3);
        chk("simul_rvalid",  bus5.rvalid, 1);
        chk("simul_rdata",   bus5.rdata, 8'h22);
        chk("simul_overrun", ovr_cnt - b_ovr, 0);

        // Asynchronous reset during data bit 4 while a byte is still pending
        snap();
        fork
            send(1'b0, 8'h0F, 1'b1, 5);
            begin
                step(26);
                #2 rst = 1'b0;
                #1;
                chk("midrst_rvalid",  bus5.rvalid, 0);
                chk("midrst_rdata",   bus5.rdata, 8'h00);
                chk("midrst_ferr",    bus5.ferr, 0);
                chk("midrst_overrun", bus5.overrun, 0);
                step(3);
                rst = 1'b1;
            end
        join
        bus5.rready = 1'b1;
        step(10);
        chk("midrst_no_byte", rv_rises - b_rises, 0);
        chk("midrst_no_ferr", ferr_cnt - b_ferr, 0);
        frame_check(8'h7E);

        // WAIT_DIV=8: next start edge 2 clocks before the stop bit ends
        send(1'b1, 8'hC5, 1'b1, 6);
        send(1'b1, 8'h5C, 1'b1, 8);
        step(10);
        chk("w8_count",   q8.size(), 2);
        chk("w8_byte0",   q8[0], 8'hC5);
        chk("w8_byte1",   q8[1], 8'h5C);
        chk("w8_ferr",    ferr8_cnt, 0);
        chk("w8_overrun", ovr8_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: deserialises the asynchronous `rxd` line into bytes and presents them on a valid/ready byte interface.
- Pairs with the core's UART transmitter on the host serial link.
- Bit period is WAIT_DIV clocks, and each bit is sampled once near its middle.
- Holds one received byte and flags framing errors and overruns.

Parameters:
WAIT_DIV, 5, clock cycles per UART bit; legal range ≥ 4. Counter width is $clog2(WAIT_DIV).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset; 0 = reset
rxd  input  1  serial line, idle high, asynchronous to clk
rdata  output  8  received byte, LSB = first data bit on the wire
rvalid  output  1  rdata holds an unconsumed byte
rready  input  1  consumer accepts rdata when rvalid && rready at a clk edge
ferr  output  1  one-cycle pulse: stop bit sampled low, byte discarded
overrun  output  1  one-cycle pulse: byte completed while buffer full and not being drained; new byte dropped

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; counters 0; sync flops and previous-sample register 1; rdata=0; rvalid=0; ferr=0; overrun=0.
- Input sync: `rxd` passes through a 2-flop synchronizer to give `rxd_s`, so line changes reach `rxd_s` 2 clocks later. `rxd_p` is `rxd_s` delayed 1 clock.
- States and transitions:
  - IDLE: on `rxd_s==0 && rxd_p==1` (falling edge), go to START with wait_cnt=0. A line held low from reset does not start a frame.
  - START: wait_cnt increments. At wait_cnt==(WAIT_DIV-1)/2, sample `rxd_s`.
    - If 1 (glitch): go to IDLE with no outputs.
    - If 0: go to DATA with wait_cnt=0 and bit_cnt=0.
  - DATA: at wait_cnt==WAIT_DIV-1, shift `rxd_s` into the MSB of the shift register (right-shift, LSB first), set wait_cnt=0, bit_cnt+1. After the 8th sample (bit_cnt==7), go to STOP.
  - STOP: at wait_cnt==WAIT_DIV-1, sample `rxd_s`.
    - If 1: complete the byte, then go to IDLE.
    - If 0: ferr=1 for one cycle, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s==1`, then go to IDLE. A break or stuck-low line produces exactly one ferr.
- Byte completion and buffer, evaluated in the cycle after the stop sample:
  - If rvalid==0, or rvalid&&rready in that same cycle: load rdata, rvalid=1 (remains 1 when simultaneous; no overrun).
  - Otherwise: rdata is unchanged, rvalid stays 1, overrun=1 for one cycle.
- Handshake:
  - rvalid&&rready with no completion in that cycle: rvalid=0 next cycle; rdata holds its value.
  - rvalid never drops without a handshake.
  - rdata is stable while rvalid=1, except when loaded on a simultaneous drain.
- Latency:
  - The sample point for bit k (start bit = 0) is (WAIT_DIV-1)/2 + k·WAIT_DIV clocks after the IDLE edge detect.
  - rvalid rises 1 clock after the stop sample.
  - From the `rxd` falling edge: 2 (sync) + 1 (edge) + (WAIT_DIV-1)/2 + 9·WAIT_DIV + 1 clocks. With WAIT_DIV=5 this is 51 clocks.
- Back-to-back frames: IDLE is re-entered 1 clock after the stop sample, so a new start edge half a bit into the stop bit is caught. A frame of up to ≈0.5-bit early start, or a ≈±5% rate mismatch, is tolerated.
- Reset mid-frame: immediate abort; partial byte discarded; no ferr/overrun; after release, waits for a fresh falling edge.
- No parity, 1 stop bit only; extra stop bits are simply idle time.

Test Plan (WAIT_DIV=5 unless stated; rready=1 unless stated):
- Frame 0x55 (start 0, bits LSB first 1,0,1,0,1,0,1,0, stop 1), each bit 5 clocks → rvalid=1 exactly 51 clocks after `rxd` falls, rdata=0x55, single-cycle rvalid, ferr=0, overrun=0. Repeat for 0x00, 0xFF and 0xA3.
- `rxd` low for 2 clocks then high → no rvalid, no ferr, state back to IDLE; a following 0x3C frame → rdata=0x3C.
- Frame 0x81 with stop bit 0, then `rxd` held low 30 clocks then high → exactly one ferr pulse, rvalid stays 0; next frame 0x42 → rdata=0x42.
- rready=0, frames 0x11 then 0x22 back-to-back → rdata=0x11, rvalid=1, one overrun pulse at the second completion; raise rready → 0x11 accepted, rvalid=0. Then the same frames with rready pulsed in the completion cycle of 0x22 → rdata=0x22, rvalid=1, no overrun.
- rst=0 asynchronously during data bit 4 of a frame, released 3 clocks later while the line continues the old frame → outputs 0 during reset; no rvalid/ferr from the partial frame until the line returns high; next full frame 0x7E → rdata=0x7E.
- WAIT_DIV=8: frames 0xC5 and 0x5C with the start bit beginning 2 clocks into the previous stop bit → both received correctly in order, no errors.
